qrisc32_prefetch: RTL and testbench
===================================

# qrisc32_prefetch

Sequential instruction prefetch buffer between the IF stage's instruction read port and instruction memory. Streams words ahead of the fetch PC into a small queue so IF sees zero-wait hits on sequential code. Any IF address outside the buffered window causes a flush and redirects prefetch to that address, so EX branches need no extra signalling. IF-facing port: Avalon-style slave. Memory-facing port: Avalon-style master.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  clock; all state on rising edge
- areset_n  in  1  asynchronous active-low reset
- if_rd  in  1  IF read request (IF holds it at 1)
- if_address  in  32  IF fetch address; bits [1:0] ignored
- if_data  out  32  instruction for if_address; valid when if_wait_req=0
- if_wait_req  out  1  1 = data not available this cycle
- mem_rd  out  1  memory read request
- mem_address  out  32  word address being prefetched, [1:0]=0
- mem_data  in  32  read data; valid in any cycle with mem_rd=1 and mem_wait_req=0
- mem_wait_req  in  1  memory stall
- miss_cnt  out  16  saturating count of flush events

## Operation
- State: circular queue of DEPTH words; head_addr (address of oldest entry); count (0..DEPTH); fetch_addr (= head_addr + 4*count, next word to request); miss_cnt.
- Window: entry k (0 ≤ k < count) holds word at head_addr+4k. All address comparisons use [31:2]; arithmetic is mod 2^32, so 0xFFFFFFFC+4 wraps to 0.
- Classification of each cycle with if_rd=1 (combinational):
  - HIT: if_address = head_addr+4k, k < count. if_data = entry k, if_wait_req=0. Entries 0..k-1 retire at the clock edge. Entry k is kept, so a stalled IF re-presenting the same address hits again.
  - PEND: if_address = fetch_addr. if_wait_req=0 only via the next cycle's HIT. This cycle if_wait_req=1, all count entries retire, and prefetch continues.
  - MISS: anything else. if_wait_req=1 and mem_rd=0. At the edge: count←0, head_addr←fetch_addr←if_address, miss_cnt+1 (saturating at 0xFFFF).
- if_rd=0: no retire, no miss; if_wait_req=1; prefetch continues.
- Prefetch: mem_rd = (count < DEPTH) & ~MISS; mem_address = fetch_addr.
  - On mem_rd & ~mem_wait_req, mem_data is pushed at the tail and fetch_addr += 4.
  - Retire and push in the same edge are both applied: count ← count − k + push.
- Full (count=DEPTH): mem_rd=0 until an entry retires. The cycle after a retire, mem_rd is back to 1.
- if_data when if_wait_req=1: 0 (nop), never stale data.

## Timing
- Reset (areset_n=0, asynchronous): count=0, head_addr=fetch_addr=0, miss_cnt=0. Outputs: mem_rd=1, mem_address=0, if_wait_req=1, if_data=0. Reset address 0 equals IF's reset PC, so the first cycle is PEND, not MISS.
- Reset asserted mid-burst: the queue is discarded immediately. Memory must tolerate an abandoned request, since Avalon with zero-latency read holds nothing in flight.
- Cold start, zero-wait memory: cycle 0 request addr 0 → cycle 1 HIT addr 0. After that, one word per cycle, sustained.
- Miss penalty with zero-wait memory:
  - Cycle N: MISS.
  - Cycle N+1: request the new address; IF sees PEND.
  - Cycle N+2: HIT.
  - Total: 2 cycles of if_wait_req=1.
- MISS has priority over a memory completion in the same cycle. That completion cannot occur, because mem_rd=0 on MISS.
- mem_wait_req=1: mem_address and mem_rd stay stable until accepted, unless a MISS intervenes. A MISS drops mem_rd for one cycle, then re-requests from the new address.

## Structure
- Shared package qrisc32_pkg holds:
  - QRISC32_NOP = 32'h0
  - QRISC32_INSTR_BYTES = 4
  - QRISC32_RESET_PC = 32'h0 (also used by IF)
- Storage: sub-module qrisc32_prefetch_mem. DEPTH×32 register array, one write port, DEPTH-way read mux selected by (rd_ptr + k), no reset on data.
- Top level: pointers, count, classification logic, miss counter. Estimated 150–250 lines.

## Test plan
- Reset, zero-wait memory holding word n = 0x1000+n; IF advances by 4 each cycle from 0 → if_wait_req=1 in cycle 0 only. Then if_data = 0x1000, 0x1001, … one per cycle. miss_cnt=0.
- IF holds address 8 for 5 cycles (pipe stall) after the queue fills → if_data = 0x1002 every cycle. mem_rd=0 once count=4. No miss counted.
- Branch: IF jumps from 0x10 to 0x200 → one MISS cycle (mem_rd=0), mem_address=0x200 next cycle, HIT returning 0x1080 two cycles after the jump. miss_cnt=1.
- mem_wait_req held 3 cycles on the request for 0x20 → mem_address stays 0x20. IF sees PEND (if_wait_req=1) until the word is accepted, then a HIT one cycle later.
- Wrap: redirect to 0xFFFFFFF8 → words at 0xFFFFFFF8, 0xFFFFFFFC, 0x0 delivered sequentially with no extra miss.
- areset_n pulsed low while count=3 → all outputs at reset values immediately. Fetching restarts from 0.

Source files
------------

// File: rtl/qrisc32_pkg.sv
// Shared qrisc32 constants and the prefetch-buffer cycle classification.
// Combinational only: no latency and no flow control.
package qrisc32_pkg;

   localparam logic [31:0] QRISC32_NOP         = 32'h0;
   localparam int unsigned QRISC32_INSTR_BYTES = 4;
   localparam logic [31:0] QRISC32_RESET_PC    = 32'h0;

   typedef enum logic [1:0] {
      CLS_IDLE,
      CLS_HIT,
      CLS_PEND,
      CLS_MISS
   } pf_cls_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/qrisc32_prefetch_mem.sv
// Prefetch queue storage: one write port, read of entry (rd_ptr + rd_ofs).
// Combinational read, write on the clock edge; the caller handles all flow control.
module qrisc32_prefetch_mem #(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_ptr,
   input  logic [31:0]   wr_dat,
   input  logic [PW-1:0] rd_ptr,
   input  logic [PW-1:0] rd_ofs,
   output logic [31:0]   rd_dat
);

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_idx;

   // Data carries no reset; validity is tracked by the count in the parent.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= wr_dat;
      end
   end

   always_comb begin
      rd_idx = rd_ptr + rd_ofs;
      rd_dat = mem_q[rd_idx];
   end

endmodule

// File: rtl/qrisc32_prefetch.sv
// Sequential instruction prefetch queue: zero-wait hits; 2 wait cycles on a redirect.
// Stalls on mem_wait_req hold mem_rd/mem_address; a full queue drops mem_rd until a retire.
module qrisc32_prefetch
   import qrisc32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        areset_n,
   input  logic        if_rd,
   input  logic [31:0] if_address,
   output logic [31:0] if_data,
   output logic        if_wait_req,
   output logic        mem_rd,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_data,
   input  logic        mem_wait_req,
   output logic [15:0] miss_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] count_q, count_d;
   logic [31:0]   head_q, head_d;
   logic [31:0]   fetch_q, fetch_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]   miss_cnt_q, miss_cnt_d;

   pf_cls_e       cls;
   logic [29:0]   ofs_w;
   logic [CW-1:0] retire_n;
   logic          push;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   rd_dat;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^if_address[1:0];

   qrisc32_prefetch_mem #(.DEPTH(DEPTH)) u_mem (
      .clk    (clk),
      .wr_en  (push),
      .wr_ptr (wr_ptr),
      .wr_dat (mem_data),
      .rd_ptr (rd_ptr_q),
      .rd_ofs (ofs_w[PW-1:0]),
      .rd_dat (rd_dat)
   );

   always_comb begin
      // Word distance from the head, modulo 2^30 so the window may straddle address 0.
      ofs_w = if_address[31:2] - head_q[31:2];
      cls   = CLS_IDLE;
      if (if_rd) begin
         if (ofs_w < 30'(count_q)) begin
            cls = CLS_HIT;
         end else if (if_address[31:2] == fetch_q[31:2]) begin
            cls = CLS_PEND;
         end else begin
            cls = CLS_MISS;
         end
      end

      retire_n = '0;
      if (cls == CLS_HIT) begin
         retire_n = CW'(ofs_w[PW-1:0]);
      end else if (cls == CLS_PEND) begin
         retire_n = count_q;
      end

      mem_rd      = (count_q != FULL) && (cls != CLS_MISS);
      push        = mem_rd && !mem_wait_req;
      wr_ptr      = rd_ptr_q + count_q[PW-1:0];
      mem_address = fetch_q;
      if_wait_req = (cls != CLS_HIT);
      if_data     = (cls == CLS_HIT) ? rd_dat : QRISC32_NOP;
      miss_cnt    = miss_cnt_q;
   end

   always_comb begin
      count_d    = count_q - retire_n + CW'(push);
      head_d     = head_q + 32'(retire_n) * QRISC32_INSTR_BYTES;
      rd_ptr_d   = rd_ptr_q + retire_n[PW-1:0];
      fetch_d    = push ? fetch_q + QRISC32_INSTR_BYTES : fetch_q;
      miss_cnt_d = miss_cnt_q;
      if (cls == CLS_MISS) begin
         count_d  = '0;
         head_d   = word_align(if_address);
         fetch_d  = word_align(if_address);
         rd_ptr_d = rd_ptr_q;
         if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         count_q    <= '0;
         head_q     <= QRISC32_RESET_PC;
         fetch_q    <= QRISC32_RESET_PC;
         rd_ptr_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         fetch_q    <= fetch_d;
         rd_ptr_q   <= rd_ptr_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_qrisc32_prefetch.sv
// Scoreboarded bench for qrisc32_prefetch against a zero-wait memory holding word n = 0x1000+n.
module tb_qrisc32_prefetch;

   logic        clk;
   logic        areset_n;
   logic        if_rd;
   logic [31:0] if_address;
   logic [31:0] if_data;
   logic        if_wait_req;
   logic        mem_rd;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_wait_req;
   logic [15:0] miss_cnt;

   int tests_run;
   int tests_failed;
   logic [31:0] exp_q[$];

   qrisc32_prefetch #(.DEPTH(4)) dut (
      .clk          (clk),
      .areset_n     (areset_n),
      .if_rd        (if_rd),
      .if_address   (if_address),
      .if_data      (if_data),
      .if_wait_req  (if_wait_req),
      .mem_rd       (mem_rd),
      .mem_address  (mem_address),
      .mem_data     (mem_data),
      .mem_wait_req (mem_wait_req),
      .miss_cnt     (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb mem_data = 32'h1000 + {2'b00, mem_address[31:2]};

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return 32'h1000 + {2'b00, addr[31:2]};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // IF read that holds its address while waiting; checks data and number of wait cycles.
   task automatic fetch(input logic [31:0] addr, input int exp_waits, input string name);
      int waits;
      logic [31:0] exp;
      exp_q.push_back(word_at(addr));
      if_rd = 1'b1;
      if_address = addr;
      waits = 0;
      @(negedge clk);
      while (if_wait_req !== 1'b0 && waits < 40) begin
         next_cycle();
         waits++;
         @(negedge clk);
      end
      exp = exp_q.pop_front();
      tests_run++;
      if (if_wait_req !== 1'b0 || if_data !== exp) begin
         tests_failed++;
         $display("FAIL %s data: got %h wait=%b, expected %h wait=0", name, if_data, if_wait_req, exp);
      end
      tests_run++;
      if (waits != exp_waits) begin
         tests_failed++;
         $display("FAIL %s waits: got %0d, expected %0d", name, waits, exp_waits);
      end
      next_cycle();
   endtask

   task automatic check_reset_outputs(input string name);
      tests_run++;
      if (mem_rd !== 1'b1 || mem_address !== 32'h0 || if_wait_req !== 1'b1 ||
          if_data !== 32'h0 || miss_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL %s: got mem_rd=%b mem_address=%h wait=%b data=%h miss=%h, expected 1 0 1 0 0",
                  name, mem_rd, mem_address, if_wait_req, if_data, miss_cnt);
      end
   endtask

   task automatic test_reset();
      areset_n = 1'b0;
      if_rd = 1'b1;
      if_address = 32'h0;
      mem_wait_req = 1'b0;
      repeat (2) next_cycle();
      check_reset_outputs("reset_state");
      areset_n = 1'b1;
   endtask

   task automatic test_stream();
      fetch(32'h0, 1, "cold_0");
      fetch(32'h4, 0, "seq_4");
   endtask

   task automatic test_stall();
      logic exp_rd;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(word_at(32'h8));
         if_address = 32'h8;
         exp_rd = (i < 3);
         @(negedge clk);
         tests_run++;
         if (if_wait_req !== 1'b0 || if_data !== exp_q.pop_front()) begin
            tests_failed++;
            $display("FAIL stall_data[%0d]: got %h wait=%b, expected 00001002 wait=0", i, if_data, if_wait_req);
         end
         tests_run++;
         if (mem_rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL stall_mem_rd[%0d]: got %b, expected %b", i, mem_rd, exp_rd);
         end
         next_cycle();
      end
      tests_run++;
      if (miss_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL stall_miss_cnt: got %0d, expected 0", miss_cnt);
      end
   endtask

   task automatic test_back_to_back();
      fetch(32'hC, 0, "full_retire_c");
      @(negedge clk);
      tests_run++;
      if (mem_rd !== 1'b1) begin
         tests_failed++;
         $display("FAIL refill_mem_rd: got %b, expected 1", mem_rd);
      end
      next_cycle();
      fetch(32'h10, 0, "seq_10");
   endtask

   task automatic test_branch();
      exp_q.push_back(word_at(32'h200));
      if_address = 32'h200;
      @(negedge clk);
      tests_run++;
      if (if_wait_req !== 1'b1 || mem_rd !== 1'b0 || if_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL branch_miss_cycle: got wait=%b mem_rd=%b data=%h, expected 1 0 0", if_wait_req, mem_rd, if_data);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (mem_address !== 32'h200 || mem_rd !== 1'b1 || if_wait_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL branch_pend_cycle: got addr=%h mem_rd=%b wait=%b, expected 200 1 1", mem_address, mem_rd, if_wait_req);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (if_wait_req !== 1'b0 || if_data !== exp_q.pop_front()) begin
         tests_failed++;
         $display("FAIL branch_hit: got %h wait=%b, expected 00001080 wait=0", if_data, if_wait_req);
      end
      tests_run++;
      if (miss_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL branch_miss_cnt: got %0d, expected 1", miss_cnt);
      end
      next_cycle();
      fetch(32'h204, 0, "post_branch_204");
   endtask

   task automatic test_wait_req();
      exp_q.push_back(word_at(32'h20));
      if_address = 32'h20;
      @(negedge clk);
      next_cycle();
      mem_wait_req = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         tests_run++;
         if (mem_address !== 32'h20 || mem_rd !== 1'b1 || if_wait_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL waitreq_hold[%0d]: got addr=%h mem_rd=%b wait=%b, expected 20 1 1", j, mem_address, mem_rd, if_wait_req);
         end
         next_cycle();
      end
      mem_wait_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (if_wait_req !== 1'b1 || mem_rd !== 1'b1) begin
         tests_failed++;
         $display("FAIL waitreq_accept: got wait=%b mem_rd=%b, expected 1 1", if_wait_req, mem_rd);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (if_wait_req !== 1'b0 || if_data !== exp_q.pop_front()) begin
         tests_failed++;
         $display("FAIL waitreq_hit: got %h wait=%b, expected 00001008 wait=0", if_data, if_wait_req);
      end
      tests_run++;
      if (miss_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL waitreq_miss_cnt: got %0d, expected 2", miss_cnt);
      end
      next_cycle();
   endtask

   task automatic test_wrap();
      fetch(32'hFFFF_FFF8, 2, "wrap_fff8");
      fetch(32'hFFFF_FFFC, 0, "wrap_fffc");
      fetch(32'h0, 0, "wrap_0");
      tests_run++;
      if (miss_cnt !== 16'd3) begin
         tests_failed++;
         $display("FAIL wrap_miss_cnt: got %0d, expected 3", miss_cnt);
      end
   endtask

   task automatic test_reset_mid();
      if_address = 32'h400;
      next_cycle();
      if_rd = 1'b0;
      repeat (3) next_cycle();
      exp_q.push_back(word_at(32'h404));
      if_rd = 1'b1;
      if_address = 32'h404;
      #2;
      tests_run++;
      if (if_wait_req !== 1'b0 || if_data !== exp_q.pop_front() || mem_address !== 32'h40C) begin
         tests_failed++;
         $display("FAIL pre_reset_hit: got %h wait=%b addr=%h, expected 00001101 0 0000040c", if_data, if_wait_req, mem_address);
      end
      areset_n = 1'b0;
      if_address = 32'h0;
      #1;
      check_reset_outputs("mid_reset");
      next_cycle();
      areset_n = 1'b1;
      fetch(32'h0, 1, "restart_0");
      fetch(32'h4, 0, "restart_4");
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      areset_n = 1'b0;
      if_rd = 1'b0;
      if_address = 32'h0;
      mem_wait_req = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_branch();
      test_wait_req();
      test_wrap();
      test_reset_mid();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
